// File: rtl/uart_word_serializer_pkg.sv
// Shared definitions for the UART word serializer.
//   state_t      : serializer FSM state encoding (3 bits)
//   BYTE_W       : width of one transmitted byte
//   count_width  : bits needed to hold the values 0..max_val (never below 1)
package uart_word_serializer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_word_serializer_fifo.sv
// sync_word_fifo: single-clock word FIFO with a registered read port.
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   wr_en, wr_data   : write strobe and word (ignored while full)
//   rd_en, rd_data   : read strobe (ignored while empty); rd_data is valid
//                      the cycle after the read strobe
//   full, empty      : status flags derived from the level
//   level            : number of stored words, 0..DEPTH
module sync_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign level   = level_reg;
    assign rd_data = rd_data_reg;

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= wr_data;
        if (rd_ok) rd_data_reg <= mem[rd_ptr_reg];
    end

endmodule

// File: rtl/uart_word_serializer.sv
// uart_word_serializer: buffers words of up to BYTES bytes and feeds them
// byte by byte into a UART transmitter using a tx_en / tx_busy handshake.
//   sys_clk, sys_rst     : clock and synchronous active-high reset
//   in_data, in_nbytes   : word and its valid byte count (0 or >BYTES = BYTES)
//   in_valid, in_ready   : input handshake; in_ready means the FIFO is not full
//   tx_busy              : transmitter busy
//   tx_en, tx_data       : one-cycle start pulse and the byte to send
//   word_done            : one-cycle pulse once the last byte of a word is sent
//   fifo_level           : words waiting in the FIFO
module uart_word_serializer
    import uart_word_serializer_pkg::*;
#(
    parameter int BYTES     = 4,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int BUSY_WAIT = 16
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic [BYTE_W*BYTES-1:0]         in_data,
    input  logic [count_width(BYTES)-1:0]   in_nbytes,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            tx_busy,
    output logic                            tx_en,
    output logic [BYTE_W-1:0]               tx_data,
    output logic                            word_done,
    output logic [count_width(DEPTH)-1:0]   fifo_level
);

    localparam int DW = BYTE_W * BYTES;
    localparam int CW = count_width(BYTES);
    localparam int TW = count_width(BUSY_WAIT);
    localparam int FW = CW + DW;

    state_t            state_reg;
    state_t            state_next;
    logic [DW-1:0]     shift_reg;
    logic [CW-1:0]     cnt_reg;
    logic [TW-1:0]     tmo_reg;
    logic              tx_en_reg;
    logic              tx_en_next;
    logic [BYTE_W-1:0] tx_data_reg;

    logic [CW-1:0]     push_nbytes;
    logic [FW-1:0]     fifo_q;
    logic [CW-1:0]     pop_nbytes;
    logic [DW-1:0]     pop_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd;

    logic              load_first;
    logic              byte_step;
    logic              tmo_clear;
    logic              tmo_inc;
    logic              last_byte;
    logic              tmo_expired;

    logic [BYTE_W-1:0] load_byte;
    logic [BYTE_W-1:0] next_byte;
    logic [DW-1:0]     load_rest;
    logic [DW-1:0]     next_rest;

    // Out-of-range counts are folded to a full word before storage.
    assign push_nbytes = (in_nbytes == '0 || in_nbytes > CW'(BYTES)) ? CW'(BYTES) : in_nbytes;

    sync_word_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (in_valid),
        .wr_data ({push_nbytes, in_data}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_q),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready   = !fifo_full;
    assign pop_nbytes = fifo_q[FW-1 -: CW];
    assign pop_data   = fifo_q[DW-1:0];

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            logic [DW-1:0] aligned;
            // Left-justify the n valid bytes so the highest valid byte is
            // in the top lane; bytes then leave from the top, shifting left.
            assign aligned   = pop_data << {CW'(BYTES) - pop_nbytes, 3'b000};
            assign load_byte = aligned[DW-1 -: BYTE_W];
            assign load_rest = aligned << BYTE_W;
            assign next_byte = shift_reg[DW-1 -: BYTE_W];
            assign next_rest = shift_reg << BYTE_W;
        end else begin : g_lsb_first
            assign load_byte = pop_data[BYTE_W-1:0];
            assign load_rest = pop_data >> BYTE_W;
            assign next_byte = shift_reg[BYTE_W-1:0];
            assign next_rest = shift_reg >> BYTE_W;
        end
    endgenerate

    assign last_byte   = (cnt_reg == CW'(1));
    assign tmo_expired = (tmo_reg == TW'(BUSY_WAIT - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (!fifo_empty) state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_ISSUE;
            ST_ISSUE:   if (!tx_busy) state_next = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_busy)          state_next = ST_WAIT_LO;
                else if (tmo_expired) state_next = ST_ISSUE;   // re-issue same byte
            end
            ST_WAIT_LO: if (!tx_busy) state_next = last_byte ? ST_DONE : ST_ISSUE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd    = 1'b0;
        tx_en_next = 1'b0;
        load_first = 1'b0;
        byte_step  = 1'b0;
        tmo_clear  = 1'b0;
        tmo_inc    = 1'b0;
        word_done  = 1'b0;
        case (state_reg)
            ST_IDLE:    fifo_rd = !fifo_empty;
            ST_LOAD:    load_first = 1'b1;
            ST_ISSUE: begin
                tmo_clear  = 1'b1;
                tx_en_next = !tx_busy;
            end
            ST_WAIT_HI: tmo_inc = !tx_busy;
            ST_WAIT_LO: byte_step = !tx_busy;
            ST_DONE:    word_done = 1'b1;
            default:    ;
        endcase
    end

    // tx_en is registered, so the pulse lands the cycle after ISSUE sees an
    // idle transmitter; tx_data was already loaded at least one cycle earlier.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_en_reg   <= 1'b0;
            tx_data_reg <= '0;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            tmo_reg     <= '0;
        end else begin
            tx_en_reg <= tx_en_next;
            if (load_first) begin
                shift_reg   <= load_rest;
                tx_data_reg <= load_byte;
                cnt_reg     <= pop_nbytes;
            end
            if (byte_step) begin
                cnt_reg <= cnt_reg - 1'b1;
                if (!last_byte) begin
                    shift_reg   <= next_rest;
                    tx_data_reg <= next_byte;
                end
            end
            if (tmo_clear)    tmo_reg <= '0;
            else if (tmo_inc) tmo_reg <= tmo_reg + 1'b1;
        end
    end

    assign tx_en   = tx_en_reg;
    assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_word_serializer.sv
module tb_uart_word_serializer;

    localparam int BUSY_CYC = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    int          cyc = 0;

    // MSB-first instance (index 0) and LSB-first instance (index 1)
    logic [31:0] m_in_data = '0,  l_in_data = '0;
    logic [2:0]  m_in_nbytes = '0, l_in_nbytes = '0;
    logic        m_in_valid = 1'b0, l_in_valid = 1'b0;
    logic        m_in_ready, l_in_ready;
    logic        m_tx_busy, l_tx_busy;
    logic        m_tx_en, l_tx_en;
    logic [7:0]  m_tx_data, l_tx_data;
    logic        m_word_done, l_word_done;
    logic [2:0]  m_fifo_level, l_fifo_level;

    // transmitter model state, per instance
    logic        mbusy [2];
    logic        hold [2];
    int          bcnt [2];
    int          ignore_n [2];
    int          en_count [2];
    int          acc_count [2];
    int          done_count [2];
    int          fall_cyc [2];
    int          arm [2];
    int          first_en_cyc [2];
    int          ign_cyc [2];
    int          ign_pending [2];
    int          retry_gap [2];
    logic [7:0]  retry_data [2];
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        lsb;
        logic [31:0] data;
        logic [2:0]  nb;
        logic [31:0] exp_seq;   // first byte sent in [31:24]
        int          exp_cnt;
    } vec_t;
    vec_t tbl [9];

    assign m_tx_busy = mbusy[0] | hold[0];
    assign l_tx_busy = mbusy[1] | hold[1];

    uart_word_serializer #(.BYTES(4), .DEPTH(4), .MSB_FIRST(1), .BUSY_WAIT(16)) u_dut_msb (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_data(m_in_data), .in_nbytes(m_in_nbytes), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .tx_busy(m_tx_busy), .tx_en(m_tx_en), .tx_data(m_tx_data),
        .word_done(m_word_done), .fifo_level(m_fifo_level)
    );

    uart_word_serializer #(.BYTES(4), .DEPTH(4), .MSB_FIRST(0), .BUSY_WAIT(16)) u_dut_lsb (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_data(l_in_data), .in_nbytes(l_in_nbytes), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .tx_busy(l_tx_busy), .tx_en(l_tx_en), .tx_data(l_tx_data),
        .word_done(l_word_done), .fifo_level(l_fifo_level)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One negedge step of the transmitter model for instance k.
    task automatic model_step(input int k, input logic en, input logic [7:0] d, input logic done);
        logic [7:0] e;
        int         qs;
        if (en) begin
            en_count[k]++;
            if (arm[k] != 0) begin
                first_en_cyc[k] = cyc;
                arm[k] = 0;
            end
            if (ignore_n[k] > 0) begin
                ignore_n[k]--;
                ign_cyc[k] = cyc;
                ign_pending[k] = 1;
            end else begin
                if (ign_pending[k] != 0) begin
                    retry_gap[k]  = cyc - ign_cyc[k];
                    retry_data[k] = d;
                    ign_pending[k] = 0;
                end
                acc_count[k]++;
                qs = (k == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    checks++;
                    $display("FAIL tx_byte_%0d: got unexpected byte %0h, none required", k, d);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("tx_byte_%0d", k), 64'(d), 64'(e));
                end
                mbusy[k] = 1'b1;
                bcnt[k]  = BUSY_CYC;
            end
        end else if (mbusy[k]) begin
            bcnt[k]--;
            if (bcnt[k] == 0) begin
                mbusy[k] = 1'b0;
                fall_cyc[k] = cyc;
            end
        end
        if (done) begin
            done_count[k]++;
            check($sformatf("word_done_timing_%0d", k), 64'(cyc), 64'(fall_cyc[k] + 1));
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < 2; k++) begin
                mbusy[k] = 1'b0;
                bcnt[k]  = 0;
            end
        end else begin
            model_step(0, m_tx_en, m_tx_data, m_word_done);
            model_step(1, l_tx_en, l_tx_data, l_word_done);
        end
    end

    task automatic expect_seq(input int k, input logic [31:0] seq, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (k == 0) q0.push_back(seq[31-8*i -: 8]);
            else        q1.push_back(seq[31-8*i -: 8]);
        end
    endtask

    // Reference byte order: n valid low bytes, highest first when msb=1.
    task automatic model_seq(input logic [31:0] data, input logic [2:0] nb, input logic msb,
                             output logic [31:0] seq, output int cnt);
        logic [7:0] b;
        cnt = (nb == 0 || nb > 4) ? 4 : int'(nb);
        seq = '0;
        for (int i = 0; i < cnt; i++) begin
            b = msb ? data[8*(cnt-1-i) +: 8] : data[8*i +: 8];
            seq[31-8*i -: 8] = b;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input int k, input logic [31:0] data, input logic [2:0] nb, output int pc);
        int waited = 0;
        if (k == 0) begin m_in_data = data; m_in_nbytes = nb; m_in_valid = 1'b1; end
        else        begin l_in_data = data; l_in_nbytes = nb; l_in_valid = 1'b1; end
        while (!((k == 0) ? m_in_ready : l_in_ready) && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        if (waited >= 3000) begin
            checks++;
            $display("FAIL push_timeout_%0d: in_ready stayed 0, required 1", k);
        end
        @(negedge sys_clk);
        pc = cyc;
        if (k == 0) m_in_valid = 1'b0;
        else        l_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int k, input int target, input string name);
        int n = 0;
        while (done_count[k] < target && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (done_count[k] < target) begin
            checks++;
            $display("FAIL %s: word_done count %0d required %0d (timeout)", name, done_count[k], target);
        end
    endtask

    initial begin
        int          pc, d0, a0, e0, c_rel, n, cnt;
        logic [31:0] seq;

        for (int k = 0; k < 2; k++) begin
            mbusy[k] = 0; hold[k] = 0; bcnt[k] = 0; ignore_n[k] = 0; en_count[k] = 0;
            acc_count[k] = 0; done_count[k] = 0; fall_cyc[k] = 0; arm[k] = 0;
            first_en_cyc[k] = 0; ign_cyc[k] = 0; ign_pending[k] = 0; retry_gap[k] = 0;
            retry_data[k] = '0;
        end

        tbl[0] = '{1'b0, 32'hA1B2C3D4, 3'd4, 32'hA1B2C3D4, 4};
        tbl[1] = '{1'b1, 32'h00001234, 3'd2, 32'h34120000, 2};
        tbl[2] = '{1'b1, 32'h00001234, 3'd0, 32'h34120000, 4};
        tbl[3] = '{1'b0, 32'h00001234, 3'd2, 32'h12340000, 2};
        tbl[4] = '{1'b0, 32'h11223344, 3'd1, 32'h44000000, 1};
        tbl[5] = '{1'b1, 32'h55667788, 3'd3, 32'h88776600, 3};
        tbl[6] = '{1'b0, 32'hDEADBEEF, 3'd7, 32'hDEADBEEF, 4};
        tbl[7] = '{1'b1, 32'hCAFEF00D, 3'd5, 32'h0DF0FECA, 4};
        tbl[8] = '{1'b0, 32'h01020304, 3'd3, 32'h02030400, 3};

        // reset state
        repeat (3) @(negedge sys_clk);
        check("rst_tx_en", 64'(m_tx_en), 64'(0));
        check("rst_tx_data", 64'(m_tx_data), 64'(0));
        check("rst_word_done", 64'(m_word_done), 64'(0));
        check("rst_fifo_level", 64'(m_fifo_level), 64'(0));
        check("rst_fifo_level_lsb", 64'(l_fifo_level), 64'(0));
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_in_ready", 64'(m_in_ready), 64'(1));

        // table-driven single words on an idle serializer
        for (int i = 0; i < 9; i++) begin
            n  = tbl[i].lsb ? 1 : 0;
            d0 = done_count[n];
            a0 = acc_count[n];
            e0 = en_count[n];
            expect_seq(n, tbl[i].exp_seq, tbl[i].exp_cnt);
            arm[n] = 1;
            push_word(n, tbl[i].data, tbl[i].nb, pc);
            wait_done(n, d0 + 1, $sformatf("vec%0d_done", i));
            repeat (3) @(negedge sys_clk);
            check($sformatf("vec%0d_latency", i), 64'(first_en_cyc[n] - pc), 64'(3));
            check($sformatf("vec%0d_bytes", i), 64'(acc_count[n] - a0), 64'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_tx_en_pulses", i), 64'(en_count[n] - e0), 64'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_done_once", i), 64'(done_count[n] - d0), 64'(1));
            check($sformatf("vec%0d_drained", i), 64'((n == 0) ? q0.size() : q1.size()), 64'(0));
        end

        // missing busy: first tx_en ignored, re-issued after the timeout
        d0 = done_count[0];
        e0 = en_count[0];
        model_seq(32'h0A0B0C0D, 3'd4, 1'b1, seq, cnt);
        expect_seq(0, seq, cnt);
        ignore_n[0] = 1;
        push_word(0, 32'h0A0B0C0D, 3'd4, pc);
        wait_done(0, d0 + 1, "retry_done");
        repeat (2) @(negedge sys_clk);
        check("retry_gap", 64'(retry_gap[0]), 64'(17));
        check("retry_data", 64'(retry_data[0]), 64'(8'h0A));
        check("retry_tx_en_pulses", 64'(en_count[0] - e0), 64'(5));

        // busy at start: no tx_en until the transmitter goes idle
        d0 = done_count[0];
        e0 = en_count[0];
        hold[0] = 1'b1;
        expect_seq(0, 32'h5A000000, 1);
        push_word(0, 32'h0000005A, 3'd1, pc);
        repeat (20) @(negedge sys_clk);
        check("busy_start_no_tx_en", 64'(en_count[0] - e0), 64'(0));
        arm[0] = 1;
        hold[0] = 1'b0;
        c_rel = cyc;
        wait_done(0, d0 + 1, "busy_start_done");
        check("busy_start_release", 64'(first_en_cyc[0] - c_rel), 64'(1));

        // back-pressure: fill the FIFO behind a stalled transmitter
        repeat (2) @(negedge sys_clk);
        d0 = done_count[0];
        a0 = acc_count[0];
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            model_seq(32'h10111213 + 32'h04040404 * i, 3'd4, 1'b1, seq, cnt);
            expect_seq(0, seq, cnt);
            push_word(0, 32'h10111213 + 32'h04040404 * i, 3'd4, pc);
        end
        check("bp_level_full", 64'(m_fifo_level), 64'(4));
        check("bp_in_ready_low", 64'(m_in_ready), 64'(0));
        model_seq(32'h24252627, 3'd4, 1'b1, seq, cnt);
        expect_seq(0, seq, cnt);
        m_in_data = 32'h24252627; m_in_nbytes = 3'd4; m_in_valid = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("bp_full_ignores_push", 64'(m_fifo_level), 64'(4));
        hold[0] = 1'b0;
        n = 0;
        while (!m_in_ready && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check("bp_accept_after_pop", 64'(done_count[0] > d0), 64'(1));
        @(negedge sys_clk);
        m_in_valid = 1'b0;
        wait_done(0, d0 + 6, "bp_done");
        repeat (2) @(negedge sys_clk);
        check("bp_bytes", 64'(acc_count[0] - a0), 64'(24));
        check("bp_drained", 64'(q0.size()), 64'(0));

        // reset mid-word with two words queued
        a0 = acc_count[0];
        for (int i = 0; i < 3; i++) begin
            model_seq(32'h31323334 + 32'h10101010 * i, 3'd4, 1'b1, seq, cnt);
            expect_seq(0, seq, cnt);
            push_word(0, 32'h31323334 + 32'h10101010 * i, 3'd4, pc);
        end
        n = 0;
        while (acc_count[0] - a0 < 2 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check("rst_mid_reached_byte2", 64'(acc_count[0] - a0 >= 2), 64'(1));
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rst_mid_tx_en", 64'(m_tx_en), 64'(0));
        check("rst_mid_fifo_level", 64'(m_fifo_level), 64'(0));
        check("rst_mid_tx_data", 64'(m_tx_data), 64'(0));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        q0.delete();
        d0 = done_count[0];
        e0 = en_count[0];
        @(negedge sys_clk);
        check("rst_mid_in_ready", 64'(m_in_ready), 64'(1));
        repeat (60) @(negedge sys_clk);
        check("rst_mid_no_word_done", 64'(done_count[0] - d0), 64'(0));
        check("rst_mid_no_tx_en", 64'(en_count[0] - e0), 64'(0));

        // fresh word after the abort
        a0 = acc_count[0];
        model_seq(32'h0F1E2D3C, 3'd4, 1'b1, seq, cnt);
        expect_seq(0, seq, cnt);
        arm[0] = 1;
        push_word(0, 32'h0F1E2D3C, 3'd4, pc);
        wait_done(0, d0 + 1, "fresh_done");
        repeat (2) @(negedge sys_clk);
        check("fresh_latency", 64'(first_en_cyc[0] - pc), 64'(3));
        check("fresh_bytes", 64'(acc_count[0] - a0), 64'(4));
        check("fresh_drained", 64'(q0.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
